skolem_sweep_ctrl: RTL and testbench

SKOLEM_SWEEP_CTRL -- requirements
Module: skolem_sweep_ctrl

---
 rtl/skolem_sweep_ctrl.sv | 172 +++++++++++++++++
 tb/tb_skolem_sweep_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_sweep_ctrl.sv
// skolem_sweep_ctrl
// Exhaustively sweeps all 256 values of an 8-bit input vector into a
// Skolem-function block under test. Each vector is compared against the
// golden model {7'h7F, ^x}. The controller reports the mismatch count, the
// first failing vector and an overall pass flag.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   start            one-cycle request to begin a sweep (IDLE only)
//   abort            cancels a sweep in progress
//   x_out[7:0]       vector driven to the block under test
//   x_valid          x_out carries a vector of the current sweep
//   y_in[7:0]        combinational response of the block under test
//   busy             controller is not IDLE
//   done             one-cycle pulse at sweep completion
//   pass             last completed sweep had zero mismatches
//   err_count[8:0]   mismatch count of the current or last sweep
//   first_fail[7:0]  first mismatching vector
//   first_fail_valid first_fail holds a captured value
module skolem_sweep_ctrl #(
  parameter int unsigned SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] x_out,
  output logic       x_valid,
  input  logic [7:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail,
  output logic       first_fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0] SETTLE_LD = (SETTLE == 0) ? 2'd0 : 2'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [1:0] cnt_q, cnt_d;
  logic [8:0] err_q, err_d;
  logic [7:0] ff_q, ff_d;
  logic       ffv_q, ffv_d;
  logic       pass_q, pass_d;
  logic       do_check;
  logic       mismatch;

  function automatic logic [7:0] golden(input logic [7:0] x);
    return {7'h7F, ^x};
  endfunction

  assign mismatch = (y_in != golden(vec_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 8'd0;
      cnt_q   <= 2'd0;
      err_q   <= 9'd0;
      ff_q    <= 8'd0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ff_d     = ff_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    do_check = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 8'd0;
          err_d   = 9'd0;
          ff_d    = 8'd0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (SETTLE == 0) begin
          do_check = 1'b1;
        end else begin
          // The DRIVE and CHECK cycles each count toward the SETTLE+1 cycles
          // per vector, so only SETTLE-1 WAIT cycles sit between them.
          cnt_d   = SETTLE_LD;
          state_d = (SETTLE == 1) ? S_CHECK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          do_check = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_check) begin
      if (mismatch) begin
        err_d = err_q + 9'd1;
        if (!ffv_q) begin
          ff_d  = vec_q;
          ffv_d = 1'b1;
        end
      end
      if (vec_q == 8'hFF) begin
        // pass is settled at the final check so it is already valid
        // while the done pulse is high.
        state_d = S_DONE;
        pass_d  = (err_d == 9'd0);
      end else begin
        vec_d   = vec_q + 8'd1;
        state_d = S_DRIVE;
      end
    end
  end

  assign x_out            = vec_q;
  assign x_valid          = (state_q == S_DRIVE) || (state_q == S_WAIT) ||
                            (state_q == S_CHECK);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
module tb_skolem_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance with SETTLE=0
  logic       start0, abort0;
  logic [7:0] x0, y0, ff0;
  logic       xv0, busy0, done0, pass0, ffv0;
  logic [8:0] err0;
  int         mode0;

  // Instance with SETTLE=2
  logic       start2, abort2;
  logic [7:0] x2, y2, ff2;
  logic       xv2, busy2, done2, pass2, ffv2;
  logic [8:0] err2;
  int         ph2;

  int cmp_n = 0;
  int bad_n = 0;

  skolem_sweep_ctrl #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .x_out(x0), .x_valid(xv0), .y_in(y0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_fail(ff0), .first_fail_valid(ffv0)
  );

  skolem_sweep_ctrl #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .x_out(x2), .x_valid(xv2), .y_in(y2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .first_fail(ff2), .first_fail_valid(ffv2)
  );

  // Block-under-test models: mode 0 correct, 1 bit0 inverted, 2 fault at A5
  always_comb begin
    y0 = {7'h7F, ^x0};
    if (mode0 == 1) y0[0] = ~y0[0];
    if (mode0 == 2 && x0 == 8'hA5) y0[3] = 1'b0;
  end

  // Phase within a 3-cycle vector slot: 0 DRIVE, 1 WAIT, 2 CHECK
  always @(posedge clk) begin
    if (!xv2) ph2 <= 0;
    else      ph2 <= (ph2 == 2) ? 0 : ph2 + 1;
  end

  always_comb begin
    y2 = (ph2 == 2) ? {7'h7F, ^x2} : ~{7'h7F, ^x2};
  end

  task automatic pulse_start0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  // Counts negedges after the start pulse until done0 is seen; -1 on timeout
  task automatic wait_done0(output int n);
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (done0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp_n++; if ({x0, xv0, busy0, done0, pass0} !== 12'h0) begin bad_n++;
      $display("FAIL reset_ctl: got %h expected 000", {x0, xv0, busy0, done0, pass0}); end
    cmp_n++; if ({err0, ff0, ffv0} !== 18'h0) begin bad_n++;
      $display("FAIL reset_res: got %h expected 00000", {err0, ff0, ffv0}); end
  endtask

  task automatic test_good_sweep();
    int n;
    mode0 = 0;
    pulse_start0();
    wait_done0(n);
    cmp_n++; if (n !== 256) begin bad_n++;
      $display("FAIL good_latency: got %0d expected 256", n); end
    cmp_n++; if (pass0 !== 1'b1) begin bad_n++;
      $display("FAIL good_pass: got %b expected 1", pass0); end
    cmp_n++; if (err0 !== 9'd0) begin bad_n++;
      $display("FAIL good_err: got %0d expected 0", err0); end
    cmp_n++; if (ffv0 !== 1'b0) begin bad_n++;
      $display("FAIL good_ffv: got %b expected 0", ffv0); end
    @(negedge clk);
    cmp_n++; if ({done0, busy0, xv0, pass0} !== 4'b0001) begin bad_n++;
      $display("FAIL good_after: got %b expected 0001", {done0, busy0, xv0, pass0}); end
    cmp_n++; if (x0 !== 8'hFF) begin bad_n++;
      $display("FAIL good_xhold: got %h expected ff", x0); end
  endtask

  task automatic test_all_fail();
    int n;
    mode0 = 1;
    pulse_start0();
    wait_done0(n);
    cmp_n++; if (n !== 256) begin bad_n++;
      $display("FAIL allf_latency: got %0d expected 256", n); end
    cmp_n++; if (err0 !== 9'd256) begin bad_n++;
      $display("FAIL allf_err: got %0d expected 256", err0); end
    cmp_n++; if ({ff0, ffv0, pass0} !== {8'h00, 1'b1, 1'b0}) begin bad_n++;
      $display("FAIL allf_ff: got ff=%h v=%b p=%b expected 00 1 0", ff0, ffv0, pass0); end
    @(negedge clk);
  endtask

  task automatic test_single_fault();
    int n;
    mode0 = 2;
    pulse_start0();
    wait_done0(n);
    cmp_n++; if (err0 !== 9'd1) begin bad_n++;
      $display("FAIL one_err: got %0d expected 1", err0); end
    cmp_n++; if ({ff0, ffv0, pass0} !== {8'hA5, 1'b1, 1'b0}) begin bad_n++;
      $display("FAIL one_ff: got ff=%h v=%b p=%b expected a5 1 0", ff0, ffv0, pass0); end
    @(negedge clk);
    // abort in IDLE must not disturb held results
    abort0 = 1'b1;
    @(negedge clk) abort0 = 1'b0;
    cmp_n++; if ({busy0, err0, ff0} !== {1'b0, 9'd1, 8'hA5}) begin bad_n++;
      $display("FAIL idle_abort: got b=%b e=%0d ff=%h expected 0 1 a5", busy0, err0, ff0); end
  endtask

  task automatic test_settle2();
    int n;
    n = -1;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (done2) begin
        n = i;
        break;
      end
    end
    cmp_n++; if (n !== 768) begin bad_n++;
      $display("FAIL s2_latency: got %0d expected 768", n); end
    cmp_n++; if ({pass2, err2, ffv2} !== {1'b1, 9'd0, 1'b0}) begin bad_n++;
      $display("FAIL s2_result: got p=%b e=%0d v=%b expected 1 0 0", pass2, err2, ffv2); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit hit;
    mode0 = 1;
    pulse_start0();
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (xv0 && x0 == 8'h40) begin
        hit = 1'b1;
        break;
      end
    end
    cmp_n++; if (hit !== 1'b1) begin bad_n++;
      $display("FAIL rmid_reach: got %b expected 1", hit); end
    rst = 1'b1;
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    abort0 = 1'b0;
    cmp_n++; if ({x0, xv0, busy0, done0, pass0, err0, ff0, ffv0} !== 30'h0) begin bad_n++;
      $display("FAIL rmid_zero: got x=%h v=%b b=%b e=%0d ff=%h fv=%b expected all 0",
               x0, xv0, busy0, err0, ff0, ffv0); end
    mode0 = 0;
    pulse_start0();
    wait_done0(n);
    cmp_n++; if ({n == 256, pass0, err0} !== {1'b1, 1'b1, 9'd0}) begin bad_n++;
      $display("FAIL rmid_fresh: got n=%0d p=%b e=%0d expected 256 1 0", n, pass0, err0); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, extra;
    bit hit;
    mode0 = 0;
    // start held high for the whole sweep
    @(negedge clk) start0 = 1'b1;
    @(negedge clk);
    wait_done0(n);
    start0 = 1'b0;
    cmp_n++; if (n !== 256) begin bad_n++;
      $display("FAIL held_latency: got %0d expected 256", n); end
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done0) extra++;
    end
    cmp_n++; if ({extra, busy0, pass0} !== {32'd0, 1'b0, 1'b1}) begin bad_n++;
      $display("FAIL held_once: got extra=%0d b=%b p=%b expected 0 0 1", extra, busy0, pass0); end

    // second sweep aborted at x=0x10
    mode0 = 1;
    pulse_start0();
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (xv0 && x0 == 8'h10) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    abort0 = 1'b1;
    @(negedge clk) abort0 = 1'b0;
    cmp_n++; if (hit !== 1'b1) begin bad_n++;
      $display("FAIL abort_reach: got %b expected 1", hit); end
    cmp_n++; if ({busy0, xv0, done0, pass0} !== 4'b0000) begin bad_n++;
      $display("FAIL abort_idle: got %b expected 0000", {busy0, xv0, done0, pass0}); end
    cmp_n++; if (!(err0 == 9'd16 || err0 == 9'd17) || ff0 !== 8'h00 || ffv0 !== 1'b1) begin
      bad_n++;
      $display("FAIL abort_partial: got e=%0d ff=%h v=%b expected 16/17 00 1", err0, ff0, ffv0); end
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done0 || busy0) extra++;
    end
    cmp_n++; if (extra !== 0) begin bad_n++;
      $display("FAIL abort_nodone: got %0d expected 0", extra); end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; mode0 = 0;
    start2 = 1'b0; abort2 = 1'b0;
    test_reset();
    test_good_sweep();
    test_all_fail();
    test_single_fault();
    test_settle2();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
